// File: rtl/pwbox_pkg.sv
`default_nettype none
// ============================================================================
// pwbox_pkg : shared constants and FSM encoding for the password-box front end
// Rev 1.0
// ============================================================================
package pwbox_pkg;

  localparam int DEFAULT_CODE_W = 4;

  // Shared with the password box so both sides agree on the code width.
  localparam logic [DEFAULT_CODE_W-1:0] PASSWORD = 4'b0100;

  localparam logic [4:0] ST_IDLE       = 5'b00001;
  localparam logic [4:0] ST_PRESS_DB   = 5'b00010;
  localparam logic [4:0] ST_PRESSED    = 5'b00100;
  localparam logic [4:0] ST_RELEASE_DB = 5'b01000;
  localparam logic [4:0] ST_HOLDOFF    = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE       = ST_IDLE,
    S_PRESS_DB   = ST_PRESS_DB,
    S_PRESSED    = ST_PRESSED,
    S_RELEASE_DB = ST_RELEASE_DB,
    S_HOLDOFF    = ST_HOLDOFF
  } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// sync2 : parameterized-width two-flop synchronizer with configurable reset value
// Rev 1.0
// ============================================================================
module sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/confirm_entry_frontend.sv
`default_nettype none
// ============================================================================
// confirm_entry_frontend : synchronizes/debounces the confirm button and
// latches the switch code per accepted press. Optional CONFIRM_HOLDOFF_EN
// adds a post-release guard interval. Rev 1.0
// ============================================================================
module confirm_entry_frontend
  import pwbox_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLDOFF_MS  = 200,
  parameter int CODE_W      = DEFAULT_CODE_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              confirm_raw_n,
  input  logic [CODE_W-1:0] cin_raw,
  output logic              confirm,
  output logic [CODE_W-1:0] cin,
  output logic              code_valid,
  output logic              busy
);

  localparam int DB_CYC  = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int HO_CYC  = CLK_HZ / 1000 * HOLDOFF_MS;
  localparam int CNT_MAX = (DB_CYC > HO_CYC) ? DB_CYC : HO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
`ifdef CONFIRM_HOLDOFF_EN
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HO_CYC - 1);
`endif

  logic              btn_s;
  logic [CODE_W-1:0] sw_s;

  // Button idles high, so its synchronizer resets to 1 to avoid a false press.
  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_btn (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (confirm_raw_n),
    .q   (btn_s)
  );

  sync2 #(.W(CODE_W), .RST_VAL('0)) u_sync_sw (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (cin_raw),
    .q   (sw_s)
  );

  fsm_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              confirm_nxt;
  logic [CODE_W-1:0] cin_nxt;
  logic              code_valid_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      confirm    <= 1'b1;
      cin        <= '0;
      code_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      confirm    <= confirm_nxt;
      cin        <= cin_nxt;
      code_valid <= code_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    confirm_nxt    = confirm;
    cin_nxt        = cin;
    code_valid_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!btn_s) begin
          state_nxt = S_PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      S_PRESS_DB: begin
        if (btn_s) begin
          state_nxt = S_IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt      = S_PRESSED;
          confirm_nxt    = 1'b0;
          cin_nxt        = sw_s;
          code_valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (btn_s) begin
          state_nxt = S_RELEASE_DB;
          cnt_nxt   = '0;
        end
      end
      S_RELEASE_DB: begin
        if (!btn_s) begin
          state_nxt = S_PRESSED;
        end else if (cnt == DB_LAST) begin
          confirm_nxt = 1'b1;
`ifdef CONFIRM_HOLDOFF_EN
          state_nxt   = S_HOLDOFF;
          cnt_nxt     = '0;
`else
          state_nxt   = S_IDLE;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef CONFIRM_HOLDOFF_EN
      // Button level is deliberately ignored until the guard interval expires.
      S_HOLDOFF: begin
        if (cnt == HO_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_confirm_entry_frontend.sv
`default_nettype none
// ============================================================================
// tb_confirm_entry_frontend : directed stimulus with a strobe scoreboard
// Rev 1.0
// ============================================================================
module tb_confirm_entry_frontend;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       confirm_raw_n = 1'b1;
  logic [3:0] cin_raw = 4'b0000;
  logic       confirm;
  logic [3:0] cin;
  logic       code_valid;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int         at;
    logic [3:0] code;
  } exp_t;
  exp_t exp_q[$];

  confirm_entry_frontend #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .HOLDOFF_MS  (8),
    .CODE_W      (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .confirm_raw_n (confirm_raw_n),
    .cin_raw       (cin_raw),
    .confirm       (confirm),
    .cin           (cin),
    .code_valid    (code_valid),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    if (code_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: code_valid=1 cin=%0h at cycle %0d, none expected", cin, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.at || cin !== e.code || confirm !== 1'b0) begin
          miscompares++;
          $display("FAIL strobe: cycle %0d cin %0h confirm %0b, expected cycle %0d cin %0h confirm 0",
                   cyc, cin, confirm, e.at, e.code);
        end
      end
    end
  end

  task automatic drive_at(input int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check_at(input int t);
    drive_at(t);
    @(negedge sys_clk);
  endtask

  task automatic push(input int at, input logic [3:0] code);
    exp_t e;
    e.at   = at;
    e.code = code;
    exp_q.push_back(e);
  endtask

  initial begin
    int t0;
    int r;
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r;

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_confirm", 32'(confirm), 32'd1);
    chk("rst_cin", 32'(cin), 32'h0);
    chk("rst_code_valid", 32'(code_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Clean press
    t0 = cyc + 3;
    drive_at(t0 - 1); cin_raw = 4'b0100;
    drive_at(t0);     confirm_raw_n = 1'b0; push(t0 + 7, 4'b0100);
    check_at(t0 + 6); chk("clean_confirm_before", 32'(confirm), 32'd1);
    check_at(t0 + 8);
    chk("clean_confirm_low", 32'(confirm), 32'd0);
    chk("clean_cin", 32'(cin), 32'h4);
    chk("clean_busy", 32'(busy), 32'd1);
    drive_at(t0 + 20); confirm_raw_n = 1'b1;
    check_at(t0 + 26); chk("clean_rel_before", 32'(confirm), 32'd0);
    check_at(t0 + 27); chk("clean_rel_high", 32'(confirm), 32'd1);
    drive_at(t0 + 45);

    // Bounce rejection
    t0 = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      drive_at(t0 + 3 * k);     confirm_raw_n = 1'b0;
      drive_at(t0 + 3 * k + 2); confirm_raw_n = 1'b1;
    end
    check_at(t0 + 25);
    chk("bounce_confirm", 32'(confirm), 32'd1);
    chk("bounce_busy", 32'(busy), 32'd0);

    // Switch change while pressed, then a release glitch
    t0 = cyc + 3;
    drive_at(t0 - 1); cin_raw = 4'b0011;
    drive_at(t0);     confirm_raw_n = 1'b0; push(t0 + 7, 4'b0011);
    drive_at(t0 + 9); cin_raw = 4'b1111;
    check_at(t0 + 12); chk("sw_change_cin", 32'(cin), 32'h3);
    drive_at(t0 + 14); confirm_raw_n = 1'b1;
    drive_at(t0 + 16); confirm_raw_n = 1'b0;
    check_at(t0 + 24);
    chk("glitch_confirm", 32'(confirm), 32'd0);
    chk("glitch_cin", 32'(cin), 32'h3);

    // Release, then re-press 3 cycles after confirm rises
    r = t0 + 30;
    drive_at(r); confirm_raw_n = 1'b1;
    check_at(r + 7); chk("rel2_confirm", 32'(confirm), 32'd1);
    drive_at(r + 10); confirm_raw_n = 1'b0;
`ifdef CONFIRM_HOLDOFF_EN
    push(r + 20, 4'b1111);
`else
    push(r + 17, 4'b1111);
`endif
    check_at(r + 16); chk("repress_busy", 32'(busy), 32'd1);
    drive_at(r + 30); confirm_raw_n = 1'b1;
    check_at(r + 37); chk("repress_rel_confirm", 32'(confirm), 32'd1);
    drive_at(r + 50);

    // Reset in the middle of PRESS_DB
    t0 = cyc + 1;
    drive_at(t0);     confirm_raw_n = 1'b0;
    drive_at(t0 + 4); sys_rst = 1'b1; confirm_raw_n = 1'b1;
    check_at(t0 + 5);
    chk("midrst_code_valid", 32'(code_valid), 32'd0);
    chk("midrst_confirm", 32'(confirm), 32'd1);
    chk("midrst_cin", 32'(cin), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    drive_at(t0 + 6); sys_rst = 1'b0;
    check_at(t0 + 20);
    chk("post_rst_confirm", 32'(confirm), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("strobes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
